// File: rtl/axis_adc_acq_gate_if.sv
// AXI-Stream bundle used on both sides of the ADC acquisition gate.
// The master drives valid/data/last and the slave drives ready.
interface axis_adc_acq_gate_if #(
  parameter int DW = 32
) ();
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [DW-1:0] tdata;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    output tready
  );
endinterface

// File: rtl/axis_adc_acq_gate.sv
// Triggered, decimating acquisition gate behind a no-backpressure ADC stream.
// Optional ACQ_TIMESTAMP_EN prefixes each frame with the cycle count at trigger.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for arm with a non-zero sample count
// S_ARMED | M/N latched, waiting for trig
// S_ACQ   | decimating input and loading kept samples into output reg
// S_DRAIN | last beat loaded, waiting for its handshake
module axis_adc_acq_gate #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 24,
  parameter int DEC_WIDTH        = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CNTR_WIDTH-1:0] cfg_samples,
  input  logic [DEC_WIDTH-1:0]  cfg_decimation,
  input  logic                  arm,
  input  logic                  trig,
  axis_adc_acq_gate_if.slave    s_axis,
  axis_adc_acq_gate_if.master   m_axis,
  output logic                  sts_busy,
  output logic                  sts_overflow,
  output logic [CNTR_WIDTH-1:0] sts_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_ACQ   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [DEC_WIDTH-1:0]  DEC_ONE = 1;

  state_e                      state_q, state_d;
  logic [CNTR_WIDTH-1:0]       samples_q, samples_d;
  logic [DEC_WIDTH-1:0]        dec_n_q, dec_n_d;
  logic [DEC_WIDTH-1:0]        dec_cnt_q, dec_cnt_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tlast_q, tlast_d;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                        ovf_q, ovf_d;
  logic [CNTR_WIDTH-1:0]       count_q, count_d;
  logic                        out_hs;
  logic                        out_free;

`ifdef ACQ_TIMESTAMP_EN
  logic [31:0]                 ts_cnt_q, ts_cnt_d;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= S_IDLE;
      samples_q <= '0;
      dec_n_q   <= '0;
      dec_cnt_q <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      samples_q <= samples_d;
      dec_n_q   <= dec_n_d;
      dec_cnt_q <= dec_cnt_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

`ifdef ACQ_TIMESTAMP_EN
  always_comb begin
    ts_cnt_d = ts_cnt_q + 32'd1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
    end
  end
`endif

  assign out_hs   = tvalid_q & m_axis.tready;
  // The output register accepts a new word when empty or when emptied this cycle.
  assign out_free = ~tvalid_q | m_axis.tready;

  always_comb begin
    state_d   = state_q;
    samples_d = samples_q;
    dec_n_d   = dec_n_q;
    dec_cnt_d = dec_cnt_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    ovf_d     = ovf_q;
    count_d   = count_q;

    if (out_hs) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (arm && (cfg_samples != '0)) begin
          state_d   = S_ARMED;
          samples_d = cfg_samples;
          dec_n_d   = (cfg_decimation == '0) ? DEC_ONE : cfg_decimation;
          ovf_d     = 1'b0;
          count_d   = '0;
        end
      end

      S_ARMED: begin
        if (trig) begin
          state_d   = S_ACQ;
          dec_cnt_d = '0;
`ifdef ACQ_TIMESTAMP_EN
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          tdata_d   = AXIS_TDATA_WIDTH'(ts_cnt_q);
`endif
        end
      end

      S_ACQ: begin
        if (s_axis.tvalid) begin
          dec_cnt_d = (dec_cnt_q >= dec_n_q - DEC_ONE) ? '0 : dec_cnt_q + DEC_ONE;
          if (dec_cnt_q == '0) begin
            if (out_free) begin
              tvalid_d = 1'b1;
              tdata_d  = s_axis.tdata;
              count_d  = (&count_q) ? count_q : count_q + CNT_ONE;
              if (count_q == samples_q - CNT_ONE) begin
                tlast_d = 1'b1;
                state_d = S_DRAIN;
              end else begin
                tlast_d = 1'b0;
              end
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
      end

      S_DRAIN: begin
        if (out_hs && tlast_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign s_axis.tready = 1'b1;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign sts_busy      = (state_q != S_IDLE);
  assign sts_overflow  = ovf_q;
  assign sts_count     = count_q;

endmodule

// File: tb/tb_axis_adc_acq_gate.sv
// Self-checking bench for axis_adc_acq_gate: directed and randomized frames
// compared against an event-level model of kept/loaded/dropped samples.
module tb_axis_adc_acq_gate;
  localparam int DW   = 32;
  localparam int CW   = 24;
  localparam int DECW = 16;
  localparam int LIM  = 512;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [CW-1:0] cfg_samples = '0;
  logic [DECW-1:0] cfg_decimation = '0;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic          sts_busy;
  logic          sts_overflow;
  logic [CW-1:0] sts_count;
  logic [31:0]   cyc = '0;

  axis_adc_acq_gate_if #(.DW(DW)) s_axis ();
  axis_adc_acq_gate_if #(.DW(DW)) m_axis ();

  axis_adc_acq_gate #(
    .AXIS_TDATA_WIDTH(DW),
    .CNTR_WIDTH(CW),
    .DEC_WIDTH(DECW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_samples(cfg_samples),
    .cfg_decimation(cfg_decimation),
    .arm(arm),
    .trig(trig),
    .s_axis(s_axis),
    .m_axis(m_axis),
    .sts_busy(sts_busy),
    .sts_overflow(sts_overflow),
    .sts_count(sts_count)
  );

  always #5 aclk = ~aclk;

  // Independent cycle count since reset, used to predict the timestamp header.
  always @(posedge aclk) cyc <= areset ? 32'd0 : cyc + 32'd1;

  int tests = 0;
  int fails = 0;

  logic [31:0] dat [0:LIM-1];
  bit          rdy [0:LIM-1];
  logic [31:0] exp_val [$];
  bit          exp_last [$];
  int          exp_cyc [$];
  logic [31:0] obs_val [$];
  bit          obs_last [$];
  int          obs_cyc [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic int next_rdy(input int from);
    for (int r = from; r < LIM; r++) if (rdy[r]) return r;
    return LIM;
  endfunction

  // stall_pct < 0 selects the fixed pattern: ready low on cycles 2..4 after trigger.
  task automatic run_frame(input string name, input int m, input int n, input bit ramp,
                           input int stall_pct, input bit armtrig, input bit noise);
    int neff, free_at, loaded, c, d, end_idx, k;
    bit ovf;
    bit pv, pl;
    logic [31:0] pd;
    neff = (n == 0) ? 1 : n;
    for (int i = 0; i < LIM; i++) begin
      dat[i] = ramp ? 32'h100 + 32'(i) : $urandom;
      if (stall_pct < 0) rdy[i] = !(i >= 2 && i <= 4);
      else rdy[i] = (i >= 64) || ($urandom_range(0, 99) >= stall_pct);
    end

    exp_val.delete(); exp_last.delete(); exp_cyc.delete();
    obs_val.delete(); obs_last.delete(); obs_cyc.delete();
    free_at = 1; loaded = 0; ovf = 0; c = 1; d = 0;
`ifdef ACQ_TIMESTAMP_EN
    d = next_rdy(1);
    exp_val.push_back(32'h0); exp_last.push_back(1'b0); exp_cyc.push_back(d);
    free_at = d;
`endif
    while (loaded < m && c < LIM - 2) begin
      if (c >= free_at) begin
        d = next_rdy(c + 1);
        exp_val.push_back(dat[c]);
        exp_last.push_back(loaded == m - 1);
        exp_cyc.push_back(d);
        free_at = d;
        loaded++;
      end else begin
        ovf = 1'b1;
      end
      c += neff;
    end
    end_idx = (d < LIM - 2) ? d : LIM - 3;

    cfg_samples = m[CW-1:0];
    cfg_decimation = n[DECW-1:0];
    arm = 1'b1;
    trig = armtrig;
    tick();
    arm = 1'b0;
    trig = 1'b0;
    cfg_samples = CW'($urandom);
    cfg_decimation = DECW'($urandom);
    chk({name, "_armed_busy"}, sts_busy, 1);
    k = $urandom_range(armtrig ? 1 : 0, 3);
    for (int w = 0; w < k; w++) begin
      chk({name, "_armed_novalid"}, m_axis.tvalid, 0);
      tick();
    end

    pv = 0; pl = 0; pd = '0;
    for (int i = 0; i <= end_idx + 1; i++) begin
      s_axis.tdata = dat[i];
      m_axis.tready = rdy[i];
      trig = (i == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      arm = (noise && i <= end_idx) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef ACQ_TIMESTAMP_EN
      if (i == 0) exp_val[0] = cyc;
`endif
      if (pv) begin
        chk({name, "_hold_valid"}, m_axis.tvalid, 1);
        chk({name, "_hold_data"}, m_axis.tdata, pd);
        chk({name, "_hold_last"}, m_axis.tlast, pl);
      end
      if (m_axis.tvalid && m_axis.tready) begin
        obs_val.push_back(m_axis.tdata);
        obs_last.push_back(m_axis.tlast);
        obs_cyc.push_back(i);
      end
      pv = m_axis.tvalid && !m_axis.tready;
      pd = m_axis.tdata;
      pl = m_axis.tlast;
      chk({name, "_busy"}, sts_busy, (i <= end_idx) ? 1 : 0);
      tick();
    end
    arm = 1'b0;
    trig = 1'b0;
    m_axis.tready = 1'b1;

    chk({name, "_nbeats"}, obs_val.size(), exp_val.size());
    for (int j = 0; j < exp_val.size(); j++) begin
      if (j < obs_val.size()) begin
        chk({name, "_beat_data"}, obs_val[j], exp_val[j]);
        chk({name, "_beat_last"}, obs_last[j], exp_last[j]);
        chk({name, "_beat_cycle"}, obs_cyc[j], exp_cyc[j]);
      end
    end
    chk({name, "_overflow"}, sts_overflow, ovf);
    chk({name, "_count"}, sts_count, m);
    chk({name, "_idle_novalid"}, m_axis.tvalid, 0);
  endtask

  initial begin
    s_axis.tvalid = 1'b1;
    s_axis.tdata = '0;
    s_axis.tlast = 1'b0;
    m_axis.tready = 1'b1;
    areset = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tlast", m_axis.tlast, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_busy", sts_busy, 0);
    chk("rst_overflow", sts_overflow, 0);
    chk("rst_count", sts_count, 0);
    chk("rst_s_tready", s_axis.tready, 1);
    areset = 1'b0;
    tick();

    run_frame("m4n1", 4, 1, 1'b1, 0, 1'b0, 1'b0);
    run_frame("m3n4", 3, 4, 1'b1, 0, 1'b0, 1'b0);
    run_frame("m5stall", 5, 1, 1'b1, -1, 1'b0, 1'b0);
    run_frame("armtrig", 2, 0, 1'b1, 0, 1'b1, 1'b0);
    run_frame("m1n3", 1, 3, 1'b0, 30, 1'b0, 1'b1);

    cfg_samples = '0;
    cfg_decimation = 16'd1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int w = 0; w < 4; w++) begin
      chk("zero_m_busy", sts_busy, 0);
      chk("zero_m_valid", m_axis.tvalid, 0);
      tick();
    end

    cfg_samples = 24'd8;
    cfg_decimation = 16'd1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    m_axis.tready = 1'b0;
    repeat (3) tick();
    chk("midacq_overflow", sts_overflow, 1);
    chk("midacq_valid", m_axis.tvalid, 1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("midrst_valid", m_axis.tvalid, 0);
    chk("midrst_last", m_axis.tlast, 0);
    chk("midrst_data", m_axis.tdata, 0);
    chk("midrst_busy", sts_busy, 0);
    chk("midrst_overflow", sts_overflow, 0);
    chk("midrst_count", sts_count, 0);
    chk("midrst_s_tready", s_axis.tready, 1);
    m_axis.tready = 1'b1;
    tick();
    run_frame("rearm", 3, 2, 1'b0, 20, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_frame("rand", $urandom_range(1, 8), $urandom_range(0, 5), 1'b0,
                $urandom_range(0, 60), 1'($urandom_range(0, 1)), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
